// File: rtl/frame_loader.sv
//------------------------------------------------------------------------------
// frame_loader : parses a width/height header plus 8-bit pixel stream and
//                writes the draw_board frame layout into RAM port A.
// Revision     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module frame_loader #(
  parameter int unsigned HRES = 640,
  parameter int unsigned VRES = 480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [16:0] address_a,
  output logic [31:0] data_a,
  output logic [3:0]  byteena_a,
  output logic        wren_a,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam logic [15:0] c_HRES = 16'(HRES);
  localparam logic [15:0] c_VRES = 16'(VRES);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_WR_W = 3'd2,
    S_WR_H = 3'd3,
    S_PIX  = 3'd4,
    S_DONE = 3'd5,
    S_ERR  = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic [18:0] cnt_q, cnt_d;
  logic [23:0] hdr_q, hdr_d;
  logic [15:0] height_q, height_d;
  logic [18:0] total_q, total_d;
  logic [16:0] address_q, address_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  be_q, be_d;
  logic        wren_q, wren_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;

  logic        w_fire;
  logic [15:0] w_width;
  logic [15:0] w_height;
  logic        w_bad;
  logic [18:0] w_total;

  assign in_ready = (state_q == S_HDR) || (state_q == S_PIX);
  assign w_fire   = in_valid && in_ready;

  // The 4th header byte is still on in_data, so height is assembled live.
  assign w_width  = hdr_q[15:0];
  assign w_height = {in_data, hdr_q[23:16]};
  assign w_bad    = (w_width == 16'd0) || (w_height == 16'd0) ||
                    (w_width > c_HRES) || (w_height > c_VRES);
  // Only meaningful once the header passed the range check.
  assign w_total  = {9'd0, w_width[9:0]} * {10'd0, w_height[8:0]};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hdr_d     = hdr_q;
    height_d  = height_q;
    total_d   = total_q;
    address_d = address_q;
    data_d    = data_q;
    be_d      = 4'h0;
    wren_d    = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    error_d   = error_q;

    case (state_q)
      S_IDLE, S_ERR: begin
        if (start) begin
          state_d = S_HDR;
          cnt_d   = 19'd0;
          error_d = 1'b0;
          busy_d  = 1'b1;
        end
      end
      S_HDR: begin
        if (w_fire) begin
          cnt_d = cnt_q + 19'd1;
          case (cnt_q[1:0])
            2'd0: hdr_d[7:0]   = in_data;
            2'd1: hdr_d[15:8]  = in_data;
            2'd2: hdr_d[23:16] = in_data;
            default: begin
              if (w_bad) begin
                state_d = S_ERR;
                error_d = 1'b1;
                busy_d  = 1'b0;
              end else begin
                state_d   = S_WR_W;
                height_d  = w_height;
                total_d   = w_total;
                address_d = 17'd0;
                data_d    = {16'h0, w_width};
                be_d      = 4'hF;
                wren_d    = 1'b1;
              end
            end
          endcase
        end
      end
      S_WR_W: begin
        state_d   = S_WR_H;
        address_d = 17'd1;
        data_d    = {16'h0, height_q};
        be_d      = 4'hF;
        wren_d    = 1'b1;
      end
      S_WR_H: begin
        state_d = S_PIX;
        cnt_d   = 19'd0;
      end
      S_PIX: begin
        if (w_fire) begin
          address_d = 17'd2 + cnt_q[18:2];
          be_d      = 4'b0001 << cnt_q[1:0];
          data_d    = {4{in_data}};
          wren_d    = 1'b1;
          cnt_d     = cnt_q + 19'd1;
          if (cnt_q == total_q - 19'd1) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 19'd0;
      hdr_q     <= 24'd0;
      height_q  <= 16'd0;
      total_q   <= 19'd0;
      address_q <= 17'd0;
      data_q    <= 32'd0;
      be_q      <= 4'h0;
      wren_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hdr_q     <= hdr_d;
      height_q  <= height_d;
      total_q   <= total_d;
      address_q <= address_d;
      data_q    <= data_d;
      be_q      <= be_d;
      wren_q    <= wren_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  assign address_a = address_q;
  assign data_a    = data_q;
  assign byteena_a = be_q;
  assign wren_a    = wren_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

`default_nettype wire

// File: tb/tb_frame_loader.sv
//------------------------------------------------------------------------------
// tb_frame_loader : directed stimulus with a write scoreboard for frame_loader.
// Revision        : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_frame_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [16:0] address_a;
  logic [31:0] data_a;
  logic [3:0]  byteena_a;
  logic        wren_a;
  logic        busy;
  logic        done;
  logic        error;

  frame_loader #(.HRES(640), .VRES(480)) dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .address_a(address_a), .data_a(data_a),
    .byteena_a(byteena_a), .wren_a(wren_a), .busy(busy), .done(done), .error(error)
  );

  always #10 clk = ~clk;

  typedef struct packed {
    logic [16:0] a;
    logic [31:0] d;
    logic [3:0]  be;
    logic        last;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         mon_e;
  int          checks = 0;
  int          errors = 0;
  int          n_wr   = 0;
  int          n_done = 0;
  logic [16:0] last_addr;
  logic [3:0]  last_be;
  int          dn0, wr0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic push_wr(input int a, input logic [31:0] d, input logic [3:0] be, input logic last);
    wr_t e;
    e.a = 17'(a); e.d = d; e.be = be; e.last = last;
    exp_q.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int   tries = 0;
    logic acc;
    in_data  = b;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      tries++;
    end while (!acc && tries < 50);
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout got=not_accepted exp=accepted byte=%h", b);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  function automatic logic [7:0] pix(input int mode, input int n);
    case (mode)
      0:       return 8'hFF;
      1:       return 8'(n) ^ 8'h5A;
      default: return 8'hAB;
    endcase
  endfunction

  task automatic load(input int w, input int h, input int npix, input int mode,
                      input bit gap, input int ign_at);
    int         total = w * h;
    logic [7:0] b;
    pulse_start();
    push_wr(0, {16'h0, 16'(w)}, 4'hF, 1'b0);
    push_wr(1, {16'h0, 16'(h)}, 4'hF, 1'b0);
    send_byte(8'(w)); send_byte(8'(w >> 8));
    send_byte(8'(h)); send_byte(8'(h >> 8));
    for (int n = 0; n < npix; n++) begin
      b = pix(mode, n);
      push_wr(2 + n / 4, {4{b}}, 4'(1 << (n % 4)), n == total - 1);
      if (n == ign_at) start = 1'b1;
      send_byte(b);
      start = 1'b0;
      if (gap) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int target);
    int cyc = 0;
    while (n_done < target && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk({name, "_done_count"}, n_done, target);
    chk({name, "_busy_low"}, busy, 1'b0);
    chk({name, "_queue_empty"}, exp_q.size(), 0);
  endtask

  task automatic check_zero(input string name);
    chk({name, "_in_ready"}, in_ready, 1'b0);
    chk({name, "_wren"}, wren_a, 1'b0);
    chk({name, "_addr"}, address_a, 17'd0);
    chk({name, "_data"}, data_a, 32'd0);
    chk({name, "_be"}, byteena_a, 4'h0);
    chk({name, "_busy"}, busy, 1'b0);
    chk({name, "_done"}, done, 1'b0);
    chk({name, "_error"}, error, 1'b0);
  endtask

  task automatic bad_hdr(input string name, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] b3);
    pulse_start();
    chk({name, "_start_clears_error"}, error, 1'b0);
    chk({name, "_busy_set"}, busy, 1'b1);
    send_byte(b0); send_byte(b1); send_byte(b2); send_byte(b3);
    in_valid = 1'b0;
    @(negedge clk);
    chk({name, "_error"}, error, 1'b1);
    chk({name, "_busy"}, busy, 1'b0);
    chk({name, "_in_ready"}, in_ready, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk({name, "_error_held"}, error, 1'b1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    fork
      forever begin
        @(negedge clk);
        if (!rst) begin
          if (wren_a) begin
            n_wr++;
            last_addr = address_a;
            last_be   = byteena_a;
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL unexpected_write got addr=%0d data=%h be=%b exp=no_write",
                       address_a, data_a, byteena_a);
            end else begin
              mon_e = exp_q.pop_front();
              if (address_a !== mon_e.a || data_a !== mon_e.d ||
                  byteena_a !== mon_e.be || done !== mon_e.last) begin
                errors++;
                $display("FAIL write got addr=%0d data=%h be=%b done=%b exp addr=%0d data=%h be=%b done=%b",
                         address_a, data_a, byteena_a, done,
                         mon_e.a, mon_e.d, mon_e.be, mon_e.last);
              end
            end
          end else if (done) begin
            checks++;
            errors++;
            $display("FAIL done_without_write got done=1 exp done=0");
          end
          if (done) n_done++;
        end
      end
    join_none

    @(posedge clk); #1;

    // 100x100 of FF at full rate
    dn0 = n_done; wr0 = n_wr;
    load(100, 100, 10000, 0, 1'b0, -1);
    wait_done("l100", dn0 + 1);
    chk("l100_write_count", n_wr - wr0, 10002);
    chk("l100_last_addr", last_addr, 17'd2501);
    chk("l100_last_be", last_be, 4'b1000);

    // Same size with in_valid low every other cycle and a stray start mid-stream
    dn0 = n_done; wr0 = n_wr;
    load(100, 100, 10000, 1, 1'b1, 50);
    wait_done("bp100", dn0 + 1);
    chk("bp100_write_count", n_wr - wr0, 10002);
    chk("bp100_last_addr", last_addr, 17'd2501);
    chk("bp100_last_be", last_be, 4'b1000);

    // Rejected headers produce no writes
    wr0 = n_wr;
    bad_hdr("w0",   8'h00, 8'h00, 8'h64, 8'h00);
    bad_hdr("w641", 8'h81, 8'h02, 8'h10, 8'h00);
    bad_hdr("h481", 8'h10, 8'h00, 8'hE1, 8'h01);
    chk("bad_no_writes", n_wr - wr0, 0);

    // 1x1 image
    dn0 = n_done; wr0 = n_wr;
    load(1, 1, 1, 2, 1'b0, -1);
    wait_done("l1x1", dn0 + 1);
    chk("l1x1_write_count", n_wr - wr0, 3);
    chk("l1x1_last_addr", last_addr, 17'd2);
    chk("l1x1_last_be", last_be, 4'b0001);

    // Maximum width and maximum height strips
    dn0 = n_done;
    load(640, 1, 640, 1, 1'b0, -1);
    wait_done("l640x1", dn0 + 1);
    chk("l640x1_last_addr", last_addr, 17'd161);
    chk("l640x1_last_be", last_be, 4'b1000);
    dn0 = n_done;
    load(1, 480, 480, 1, 1'b0, -1);
    wait_done("l1x480", dn0 + 1);
    chk("l1x480_last_addr", last_addr, 17'd121);
    chk("l1x480_last_be", last_be, 4'b1000);

    // Full-size header accepted, then reset after 37 pixels
    dn0 = n_done; wr0 = n_wr;
    load(640, 480, 37, 1, 1'b0, -1);
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    check_zero("midrst");
    in_valid = 1'b1; in_data = 8'h11;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("midrst_in_ready_idle", in_ready, 1'b0);
    in_valid = 1'b0;
    chk("midrst_write_count", n_wr - wr0, 39);
    chk("midrst_last_addr", last_addr, 17'd11);
    chk("midrst_no_done", n_done, dn0);
    chk("midrst_queue_empty", exp_q.size(), 0);

    // Full load after the abandoned one
    dn0 = n_done; wr0 = n_wr;
    load(8, 4, 32, 1, 1'b0, -1);
    wait_done("l8x4", dn0 + 1);
    chk("l8x4_write_count", n_wr - wr0, 34);
    chk("l8x4_last_addr", last_addr, 17'd9);
    chk("l8x4_last_be", last_be, 4'b1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
